// File: rtl/bypass_rf_wr_arb.sv
// ---------------------------------------------------------------------------
// bypass_rf_wr_arb
//
// Round-robin arbiter that merges up to num_req writer requests onto the two
// write ports of a register file. Each cycle it grants at most two
// requesters. Port 1 goes to the first valid requester found when scanning
// from the round-robin pointer. Port 2 goes to the next valid requester whose
// target name differs from the port-1 name, so the two ports never write the
// same register in one cycle. Grants become registered write-port outputs one
// cycle later.
//
// Parameters
//   data_width : width of write data
//   name_width : width of a register name
//   num_req    : number of requesters, 2..8
//
// Ports
//   CLK, RST              : clock (rising edge) and asynchronous active-low reset
//   REQ_V     [num_req]   : per-requester write valid
//   REQ_NAME  [num_req*name_width] : requester k at [k*name_width +: name_width]
//   REQ_DATA  [num_req*data_width] : requester k at [k*data_width +: data_width]
//   REQ_RDY   [num_req]   : combinational accept, high only for granted requesters
//   HOLD                  : suppresses every grant while high
//   WE_1/NAME_IN_1/D_IN_1 : registered write port 1
//   WE_2/NAME_IN_2/D_IN_2 : registered write port 2
//   WR_CNT    [16]        : saturating count of accepted writes
// ---------------------------------------------------------------------------
module bypass_rf_wr_arb #(
    parameter int data_width = 32,
    parameter int name_width = 2,
    parameter int num_req    = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [num_req-1:0]            REQ_V,
    input  logic [num_req*name_width-1:0] REQ_NAME,
    input  logic [num_req*data_width-1:0] REQ_DATA,
    output logic [num_req-1:0]            REQ_RDY,
    input  logic                          HOLD,
    output logic [name_width-1:0]         NAME_IN_1,
    output logic [data_width-1:0]         D_IN_1,
    output logic                          WE_1,
    output logic [name_width-1:0]         NAME_IN_2,
    output logic [data_width-1:0]         D_IN_2,
    output logic                          WE_2,
    output logic [15:0]                   WR_CNT
);

    // Pointer width; SW has one extra bit so ptr + offset cannot overflow
    // before the explicit modulo reduction.
    localparam int PW = $clog2(num_req);
    localparam int SW = PW + 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(num_req - 1);

    logic [PW-1:0]         ptr_q;
    logic [PW-1:0]         ptr_d;
    logic [15:0]           cnt_q;
    logic [15:0]           cnt_d;
    logic                  we1_q;
    logic                  we2_q;
    logic [name_width-1:0] name1_q;
    logic [name_width-1:0] name2_q;
    logic [data_width-1:0] d1_q;
    logic [data_width-1:0] d2_q;

    logic [name_width-1:0] name_arr [num_req];
    logic [data_width-1:0] data_arr [num_req];
    logic [PW-1:0]         scan_idx [num_req];

    logic                  grant_en;
    logic                  g1_v;
    logic                  g2_v;
    logic [PW-1:0]         g1_idx;
    logic [PW-1:0]         g2_idx;
    logic [PW-1:0]         last_idx;
    logic [16:0]           cnt_sum;

    genvar gi;

    // Unflatten the per-requester name and data buses.
    generate
        for (gi = 0; gi < num_req; gi++) begin : g_unpack
            assign name_arr[gi] = REQ_NAME[gi*name_width +: name_width];
            assign data_arr[gi] = REQ_DATA[gi*data_width +: data_width];
        end
    endgenerate

    // scan_idx[i] = (ptr + i) mod num_req. The wrap is a compare-and-subtract
    // rather than a bit truncation so non-power-of-two num_req works too.
    generate
        for (gi = 0; gi < num_req; gi++) begin : g_scan
            logic [SW-1:0] sum;
            assign sum = {1'b0, ptr_q} + SW'(gi);
            assign scan_idx[gi] = (sum >= SW'(num_req)) ? PW'(sum - SW'(num_req))
                                                        : PW'(sum);
        end
    endgenerate

    // Grants are allowed only while out of reset and not held. Gating on RST
    // keeps REQ_RDY low during reset, because the registers cannot capture
    // anything then.
    assign grant_en = RST & ~HOLD;

    // Two-winner scan in round-robin order. A port-2 candidate that targets
    // the same name as the port-1 winner is passed over, and that requester
    // stays pending for a later cycle.
    always_comb begin
        g1_v   = 1'b0;
        g2_v   = 1'b0;
        g1_idx = '0;
        g2_idx = '0;
        for (int i = 0; i < num_req; i++) begin
            if (grant_en && REQ_V[scan_idx[i]]) begin
                if (!g1_v) begin
                    g1_v   = 1'b1;
                    g1_idx = scan_idx[i];
                end else if (!g2_v && (name_arr[scan_idx[i]] != name_arr[g1_idx])) begin
                    g2_v   = 1'b1;
                    g2_idx = scan_idx[i];
                end
            end
        end
    end

    // Accept strobes are exactly the grant set.
    always_comb begin
        REQ_RDY = '0;
        for (int k = 0; k < num_req; k++) begin
            REQ_RDY[k] = (g1_v && (g1_idx == PW'(k))) || (g2_v && (g2_idx == PW'(k)));
        end
    end

    // The pointer moves past the last requester granted in scan order, which
    // is the port-2 winner when there is one.
    assign last_idx = g2_v ? g2_idx : g1_idx;

    always_comb begin
        ptr_d = ptr_q;
        if (g1_v) begin
            ptr_d = (last_idx == LAST_IDX) ? '0 : last_idx + PW'(1);
        end
    end

    // Saturating write counter. The 17-bit sum catches 0xFFFE + 2 as well as
    // 0xFFFF + 1.
    assign cnt_sum = {1'b0, cnt_q} + 17'(g1_v) + 17'(g2_v);
    assign cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

    // The asynchronous reset also clears a write that has been registered but
    // not yet consumed, so no partial write can reach the register file.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            we1_q   <= 1'b0;
            we2_q   <= 1'b0;
            name1_q <= '0;
            name2_q <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            we1_q <= g1_v;
            we2_q <= g2_v;
            // An unused port keeps its last name and data; only WE drops.
            if (g1_v) begin
                name1_q <= name_arr[g1_idx];
                d1_q    <= data_arr[g1_idx];
            end
            if (g2_v) begin
                name2_q <= name_arr[g2_idx];
                d2_q    <= data_arr[g2_idx];
            end
        end
    end

    assign WE_1      = we1_q;
    assign NAME_IN_1 = name1_q;
    assign D_IN_1    = d1_q;
    assign WE_2      = we2_q;
    assign NAME_IN_2 = name2_q;
    assign D_IN_2    = d2_q;
    assign WR_CNT    = cnt_q;

endmodule
